pulse_meter: RTL and testbench

//   Downstream consumer of the pulse/signal generators. Samples one asynchronous

---
 rtl/pulse_meter.sv | 222 ++++++++++++++++++++++
 tb/tb_pulse_meter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// -----------------------------------------------------------------------------
// pulse_meter
//   Samples one asynchronous pulse train and measures, for each period, the
//   high time and the full rise-to-rise period in clock cycles. Every
//   completed period produces one result on a valid/ready output port.
//
// Parameters
//   CNT_W        width of the width/period/pulse_cnt fields; the internal
//                counters saturate at 2^CNT_W-1
//   SYNC_STAGES  number of synchroniser flops on sig_in (2 or more)
//
// Ports
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high; clears all state
//   enable     in   1      1 = measure; 0 = abort to IDLE and clear ovr
//   sig_in     in   1      asynchronous pulse train under measurement
//   rdy        in   1      consumer ready
//   vld        out  1      result valid
//   width      out  CNT_W  high-time cycles of the last complete period
//   period     out  CNT_W  rise-to-rise cycles of the last complete period
//   sat        out  1      width or period saturated in this result
//   ovr        out  1      sticky: a result was dropped while vld && !rdy
//   pulse_cnt  out  CNT_W  number of results produced (wraps)
//   dbg_state  out  2      current measurement state (0 IDLE, 1 HIGH, 2 LOW)
//
// Build option
//   PULSE_METER_GLITCH_FILTER_EN  when defined, the synchronised level is
//   only accepted after two consecutive equal samples. Single-cycle glitches
//   are ignored and the input latency grows by one cycle.
//
// Handshake
//   A result transfers on a rising edge where vld && rdy. vld then falls
//   unless a new result loads on that same edge. While vld && !rdy the
//   outputs stay stable. A result arriving in that condition is dropped,
//   ovr is set, and pulse_cnt still counts it.
// -----------------------------------------------------------------------------
module pulse_meter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             rdy,
  output logic             vld,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             sat,
  output logic             ovr,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Input path: synchroniser, optional glitch filter, edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_s;
  logic                   r_s_d;
  logic                   w_rise;
  logic                   w_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PULSE_METER_GLITCH_FILTER_EN
  // r_samp holds the previous synchronised sample. When it agrees with the
  // current sample, that level passes straight through. Otherwise the last
  // accepted level (r_filt) is kept. A new level therefore shows up one cycle
  // after the raw synchroniser output, and a one-cycle excursion never shows up.
  logic r_samp;
  logic r_filt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_samp <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_samp <= w_sync;
      r_filt <= w_s;
    end
  end

  assign w_s = (w_sync == r_samp) ? w_sync : r_filt;
`else
  assign w_s = w_sync;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s_d <= 1'b0;
    end else begin
      r_s_d <= w_s;
    end
  end

  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  // ---------------------------------------------------------------------------
  // Result arithmetic (taken from the counters on the closing rise)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_lcnt;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_period;
  logic             w_sat;

  // The sum is one bit wider so that an overflow clamps instead of wrapping.
  assign w_sum    = {1'b0, r_hcnt} + {1'b0, r_lcnt};
  assign w_period = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
  assign w_sat    = (r_hcnt == CNT_MAX) || (r_lcnt == CNT_MAX) ||
                    (w_sum >= {1'b0, CNT_MAX});

  // ---------------------------------------------------------------------------
  // Measurement FSM and output registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic             r_vld;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_period;
  logic             r_sat;
  logic             r_ovr;
  logic [CNT_W-1:0] r_pulse_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hcnt      <= '0;
      r_lcnt      <= '0;
      r_vld       <= 1'b0;
      r_width     <= '0;
      r_period    <= '0;
      r_sat       <= 1'b0;
      r_ovr       <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      // The consumer side keeps working while disabled, so a held result
      // can still be drained.
      if (r_vld && rdy) begin
        r_vld <= 1'b0;
      end

      if (!enable) begin
        r_state <= ST_IDLE;
        r_hcnt  <= '0;
        r_lcnt  <= '0;
        r_ovr   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Only an edge arms the meter. A level already high is ignored.
            if (w_rise) begin
              r_state <= ST_HIGH;
              r_hcnt  <= CNT_ONE;
            end
          end

          ST_HIGH: begin
            if (w_fall) begin
              r_state <= ST_LOW;
              r_lcnt  <= CNT_ONE;
            end else if (r_hcnt != CNT_MAX) begin
              r_hcnt <= r_hcnt + CNT_ONE;
            end
          end

          ST_LOW: begin
            if (w_rise) begin
              // This rise closes one period and opens the next one.
              r_state     <= ST_HIGH;
              r_hcnt      <= CNT_ONE;
              r_lcnt      <= '0;
              r_pulse_cnt <= r_pulse_cnt + CNT_ONE;
              if (!r_vld || rdy) begin
                r_vld    <= 1'b1;
                r_width  <= r_hcnt;
                r_period <= w_period;
                r_sat    <= w_sat;
              end else begin
                r_ovr <= 1'b1;
              end
            end else if (r_lcnt != CNT_MAX) begin
              r_lcnt <= r_lcnt + CNT_ONE;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign vld       = r_vld;
  assign width     = r_width;
  assign period    = r_period;
  assign sat       = r_sat;
  assign ovr       = r_ovr;
  assign pulse_cnt = r_pulse_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pulse_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_meter
//   Drives pulse_meter with trains described as (high, low) segment lengths.
//   Expected results come from the segment lengths themselves: each rise that
//   closes a full high+low period yields {sat, period, width}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_meter;

  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int RW    = 2 * CNT_W + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             sig_in;
  logic             rdy;
  logic             vld;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic             sat;
  logic             ovr;
  logic [CNT_W-1:0] pulse_cnt;
  logic [1:0]       dbg_state;

  always #5 clock = ~clock;

  pulse_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .rdy       (rdy),
    .vld       (vld),
    .width     (width),
    .period    (period),
    .sat       (sat),
    .ovr       (ovr),
    .pulse_cnt (pulse_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model state
  // ---------------------------------------------------------------------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [RW-1:0] exp_q[$];     // {sat, period, width} expected to transfer
  int           m_high;        // last complete high length seen by the model
  int           m_low;         // low length following it (grows while idle)
  bit           m_armed;       // a full high has been seen since arming
  bit           hold_mode;     // rdy held low: first result is held, rest drop
  bit           held_v;
  logic [RW-1:0] held;
  bit           exp_ovr;
  int           exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] expect_result(input int h, input int l);
    int w;
    int p;
    bit s;
    w = (h > MAXV) ? MAXV : h;
    p = (h + l > MAXV) ? MAXV : h + l;
    s = (h >= MAXV) || (l >= MAXV) || (h + l >= MAXV);
    return {s, p[CNT_W-1:0], w[CNT_W-1:0]};
  endfunction

  task automatic produce(input logic [RW-1:0] r);
    exp_pc++;
    if (hold_mode) begin
      if (!held_v) begin
        held   = r;
        held_v = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else begin
      exp_q.push_back(r);
    end
  endtask

  task automatic model_reset();
    m_armed   = 1'b0;
    m_high    = 0;
    m_low     = 0;
    hold_mode = 1'b0;
    held_v    = 1'b0;
    held      = '0;
    exp_ovr   = 1'b0;
    exp_pc    = 0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  // Checks any transfer that happens on the coming rising edge, then advances
  // to the next falling edge.
  task automatic tick();
    logic [RW-1:0] e;
    if (vld === 1'b1 && rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", {31'b0, vld}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("width", {24'b0, width}, {24'b0, e[CNT_W-1:0]});
        chk("period", {24'b0, period}, {24'b0, e[2*CNT_W-1:CNT_W]});
        chk("sat", {31'b0, sat}, {31'b0, e[2*CNT_W]});
      end
    end
    @(negedge clock);
  endtask

  task automatic hold_level(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) tick();
  endtask

  task automatic pulse(input int h, input int l);
    bit merged;
    merged = 1'b0;
`ifdef PULSE_METER_GLITCH_FILTER_EN
    // A one-cycle high is swallowed: it just lengthens the current low.
    if (h == 1) begin
      merged = 1'b1;
      if (m_armed) m_low += h + l;
    end
`endif
    if (!merged) begin
      if (m_armed && enable) produce(expect_result(m_high, m_low));
      m_high  = h;
      m_low   = l;
      m_armed = enable;
    end
    hold_level(1'b1, h);
    hold_level(1'b0, l);
  endtask

  task automatic idle(input int n);
    if (m_armed) m_low += n;
    hold_level(1'b0, n);
  endtask

  task automatic set_enable(input logic en);
    enable = en;
    if (!en) begin
      m_armed = 1'b0;
      exp_ovr = 1'b0;
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_vld"}, {31'b0, vld}, {31'b0, held_v});
    chk({tag, "_width"}, {24'b0, width}, {24'b0, held[CNT_W-1:0]});
    chk({tag, "_period"}, {24'b0, period}, {24'b0, held[2*CNT_W-1:CNT_W]});
    chk({tag, "_sat"}, {31'b0, sat}, {31'b0, held[2*CNT_W]});
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_drain"}, exp_q.size(), 32'd0);
    chk({tag, "_pulse_cnt"}, {24'b0, pulse_cnt}, exp_pc % 256);
    chk({tag, "_ovr"}, {31'b0, ovr}, {31'b0, exp_ovr});
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    rdy    = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);

    // Reset state
    chk("rst_vld", {31'b0, vld}, 32'd0);
    chk("rst_width", {24'b0, width}, 32'd0);
    chk("rst_period", {24'b0, period}, 32'd0);
    chk("rst_sat", {31'b0, sat}, 32'd0);
    chk("rst_ovr", {31'b0, ovr}, 32'd0);
    chk("rst_pulse_cnt", {24'b0, pulse_cnt}, 32'd0);

    reset = 1'b0;
    rdy   = 1'b1;
    set_enable(1'b1);

    // 5 high / 3 low train, always ready
    repeat (5) pulse(5, 3);
    idle(8);
    check_drained("t1");

    // Consumer stalls across three periods
    pulse(5, 3);
    hold_mode = 1'b1;
    rdy       = 1'b0;
    repeat (3) pulse(5, 3);
    idle(8);
    check_held("t2_held");
    check_drained("t2");
    hold_mode = 1'b0;
    exp_q.push_back(held);
    held_v = 1'b0;
    rdy    = 1'b1;
    idle(1);
    chk("t2_vld_after_xfer", {31'b0, vld}, 32'd0);

    // Disable in LOW with a result pending
    hold_mode = 1'b1;
    rdy       = 1'b0;
    pulse(5, 3);
    idle(4);
    set_enable(1'b0);
    idle(3);
    check_held("t3_disabled");
    chk("t3_ovr_cleared", {31'b0, ovr}, {31'b0, exp_ovr});
    hold_mode = 1'b0;
    exp_q.push_back(held);
    held_v = 1'b0;
    rdy    = 1'b1;
    idle(2);
    chk("t3_vld_drained", {31'b0, vld}, 32'd0);
    set_enable(1'b1);
    pulse(5, 3);
    idle(8);
    check_drained("t3_first_pulse");
    chk("t3_no_result", {31'b0, vld}, 32'd0);
    pulse(4, 4);
    pulse(4, 4);
    idle(8);
    check_drained("t3_rearmed");

    // Random train
    repeat (20) pulse($urandom_range(2, 12), $urandom_range(2, 12));
    idle(8);
    check_drained("t4_random");

    // One-cycle glitch inside a 6/6 train
    pulse(6, 6);
    pulse(6, 2);
    pulse(1, 3);
    pulse(6, 6);
    pulse(6, 6);
    idle(8);
    check_drained("t5_glitch");

    // Saturation boundaries
    pulse(200, 55);
    pulse(100, 54);
    pulse(260, 5);
    pulse(250, 10);
    pulse(3, 3);
    idle(8);
    check_drained("t6_sat");

    // pulse_cnt wrap
    repeat (240) pulse(2, 2);
    idle(8);
    check_drained("t7_wrap");

    // Reset in the middle of a high phase
    hold_mode = 1'b1;
    rdy       = 1'b0;
    repeat (3) pulse(3, 3);
    hold_level(1'b1, 6);
    #2;
    reset  = 1'b1;
    sig_in = 1'b0;
    #1;
    chk("t8_vld", {31'b0, vld}, 32'd0);
    chk("t8_width", {24'b0, width}, 32'd0);
    chk("t8_period", {24'b0, period}, 32'd0);
    chk("t8_sat", {31'b0, sat}, 32'd0);
    chk("t8_ovr", {31'b0, ovr}, 32'd0);
    chk("t8_pulse_cnt", {24'b0, pulse_cnt}, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    rdy   = 1'b1;
    pulse(4, 4);
    idle(8);
    check_drained("t8_first_pulse");
    chk("t8_no_result", {31'b0, vld}, 32'd0);
    pulse(4, 4);
    pulse(4, 4);
    idle(8);
    check_drained("t8_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
